// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
//   piso_state_e : FSM state encoding (ST_IDLE, ST_SHIFT)
//   frame_len()  : number of serial bits per frame (data bits plus optional parity)
//   cnt_w()      : width of the remaining-bits counter for a given data width
// Optional feature macro used by the users of this package: PISO_PARITY_EN.
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Frame length: one serial bit per data bit, plus a trailing parity bit if enabled.
  function automatic int frame_len(input int width, input bit parity);
    return parity ? (width + 32'sd1) : width;
  endfunction

  // Counter width: must hold 0..WIDTH+1 without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(width + 32'sd2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Loadable down-counter that tracks the frame bits still to be sent.
// The count saturates at zero so it can never wrap.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count -> 0)
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one
//   count_o    : current count
//   tc_o       : terminal count, high when count_o == 1 and en_i is set
// Optional feature macro in this design: PISO_PARITY_EN (not used here).
// -----------------------------------------------------------------------------
module piso_bit_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: load wins, otherwise decrement when enabled and non-zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != {CW{1'b0}})) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && (count_q == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Captures a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per shift_en tick. ser_out and ser_valid come straight from flops.
// Parameters:
//   WIDTH      : data word width (>= 2)
//   LSB_FIRST  : 1 = bit 0 first, 0 = bit WIDTH-1 first
//   IDLE_LEVEL : ser_out level while no frame is in flight
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   load_valid / load_ready / load_data : parallel load handshake
//   shift_en   : per-bit advance tick
//   ser_out / ser_valid : serial bit and frame-bit qualifier
//   workload   : frame bits remaining (0 = free)
//   done       : one-cycle pulse after the last frame bit is retired
// Optional feature macro: PISO_PARITY_EN -- appends an even-parity bit
// (XOR of the loaded word) after the data bits, whatever the bit order.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 44,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  CW         = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [CW-1:0]    workload,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int            FRAME_LEN   = frame_len(WIDTH, PAR_EN);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             done_q, done_d;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic             cnt_tc_s;
  logic [CW-1:0]    cnt_s;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  // Even parity of a data word.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  // Bit that sits at the output end of the shift register.
  function automatic logic head_of(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  piso_bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load_s),
    .load_val_i(FRAME_LEN_C),
    .en_i      (cnt_en_s),
    .count_o   (cnt_s),
    .tc_o      (cnt_tc_s)
  );

  // Next-state, datapath and next-output decode. The serial outputs are
  // computed one edge ahead so they can be driven from flops.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    done_d      = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d     = ST_SHIFT;
          shreg_d     = load_data;
          cnt_load_s  = 1'b1;
          ser_out_d   = head_of(load_data);
          ser_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
          parity_d    = even_parity(load_data);
`endif
        end else begin
          ser_out_d   = IDLE_LEVEL;
          ser_valid_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          cnt_en_s = 1'b1;
          if (LSB_FIRST) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_tc_s) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            ser_out_d   = IDLE_LEVEL;
            ser_valid_d = 1'b0;
          end else begin
`ifdef PISO_PARITY_EN
            // Two bits left before this tick means the parity bit is next.
            if (cnt_s == CW'(2)) begin
              ser_out_d = parity_q;
            end else begin
              ser_out_d = head_of(shreg_d);
            end
`else
            ser_out_d = head_of(shreg_d);
`endif
          end
        end else begin
          // Stall: everything holds.
          cnt_en_s = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ser_out_d   = IDLE_LEVEL;
        ser_valid_d = 1'b0;
      end
    endcase
  end

  // State, shift register and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  // Latched parity bit for the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign load_ready = (state_q == ST_IDLE);
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign workload   = cnt_s;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two serializer instances: A (WIDTH=8, LSB first, idle level 0) and
// B (WIDTH=44, MSB first, idle level 1). Each frame is checked against the
// bit list derived from the loaded word; shift_en is tied high, pulsed every
// 4th cycle or random. Honours PISO_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WA  = 8;
  localparam int WB  = 44;
  localparam int CWA = $clog2(WA + 2);
  localparam int CWB = $clog2(WB + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Common stimulus, steered to the selected instance.
  int          sel;
  logic        c_valid;
  logic [63:0] c_data;
  logic        c_shift;

  logic           a_load_valid, a_load_ready, a_shift_en, a_ser_out, a_ser_valid, a_done;
  logic [WA-1:0]  a_load_data;
  logic [CWA-1:0] a_workload;
  logic           b_load_valid, b_load_ready, b_shift_en, b_ser_out, b_ser_valid, b_done;
  logic [WB-1:0]  b_load_data;
  logic [CWB-1:0] b_workload;

  assign a_load_valid = (sel == 0) && c_valid;
  assign a_shift_en   = (sel == 0) && c_shift;
  assign a_load_data  = c_data[WA-1:0];
  assign b_load_valid = (sel == 1) && c_valid;
  assign b_shift_en   = (sel == 1) && c_shift;
  assign b_load_data  = c_data[WB-1:0];

  piso_serializer #(.WIDTH(WA), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_data(a_load_data), .shift_en(a_shift_en), .ser_out(a_ser_out),
    .ser_valid(a_ser_valid), .workload(a_workload), .done(a_done)
  );

  piso_serializer #(.WIDTH(WB), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_data(b_load_data), .shift_en(b_shift_en), .ser_out(b_ser_out),
    .ser_valid(b_ser_valid), .workload(b_workload), .done(b_done)
  );

  // Outputs of the selected instance.
  logic m_valid, m_out, m_ready, m_done;
  int   m_work;
  always_comb begin
    if (sel == 0) begin
      m_valid = a_ser_valid; m_out = a_ser_out; m_ready = a_load_ready;
      m_done  = a_done;      m_work = int'(a_workload);
    end else begin
      m_valid = b_ser_valid; m_out = b_ser_out; m_ready = b_load_ready;
      m_done  = b_done;      m_work = int'(b_workload);
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected i-th frame bit of word w on instance d, from the frame rules.
  function automatic int exp_bit(input int d, input logic [63:0] w, input int i);
    int W;
    logic [63:0] mask;
    W = (d == 1) ? WB : WA;
    mask = (64'd1 << W) - 64'd1;
    if (i >= W) return int'(^(w & mask));
    if (d == 0) return int'(w[i]);
    return int'(w[W-1-i]);
  endfunction

  // One frame on instance d. mode: 0 shift_en high, 1 every 4th cycle, 2 random.
  // busy: hold load_valid with 8'hFF through the frame. pre: load already presented.
  task automatic run_frame(input int d, input logic [63:0] w, input int mode,
                           input bit busy, input bit pre);
    int fl, rem, idx, cyc, guard, idle;
    bit tick;
    sel  = d;
    fl   = ((d == 1) ? WB : WA) + PAR;
    idle = (d == 1) ? 1 : 0;
    if (!pre) begin
      guard = 0;
      while (!m_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("ready_wait", int'(m_ready), 1);
      c_valid = 1'b1;
      c_data  = w;
      c_shift = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    if (busy) begin
      c_valid = 1'b1;
      c_data  = 64'hFF;
    end else begin
      c_valid = 1'b0;
    end
    chk("start_workload", m_work, fl);
    rem = fl; idx = 0; cyc = 0;
    while (rem > 0 && cyc < 1000) begin
      chk("ser_valid", int'(m_valid), 1);
      chk("ser_out", int'(m_out), exp_bit(d, w, idx));
      chk("workload", m_work, rem);
      chk("load_ready_busy", int'(m_ready), 0);
      chk("done_low", int'(m_done), 0);
      case (mode)
        0:       tick = 1'b1;
        1:       tick = ((cyc % 4) == 3);
        default: tick = 1'($urandom_range(0, 1));
      endcase
      c_shift = tick;
      @(posedge clk); #1;
      cyc++;
      if (tick) begin
        idx++;
        rem--;
      end
    end
    chk("frame_end_in_budget", int'(rem == 0), 1);
    chk("done_pulse", int'(m_done), 1);
    chk("idle_valid", int'(m_valid), 0);
    chk("idle_out", int'(m_out), idle);
    chk("idle_workload", m_work, 0);
    chk("idle_ready", int'(m_ready), 1);
    if (mode == 0) chk("frame_cycles", cyc, fl);
    if (mode == 1) chk("frame_cycles_stall", cyc, 4 * fl);
    if (!busy) begin
      c_shift = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("done_once", int'(m_done), 0);
      chk("gap_valid", int'(m_valid), 0);
      chk("gap_workload", m_work, 0);
    end
  endtask

  initial begin
    logic [63:0] w;
    int d, mode;
    sel = 0; c_valid = 1'b0; c_data = 64'd0; c_shift = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", int'(a_ser_valid), 0);
    chk("rst_a_out", int'(a_ser_out), 0);
    chk("rst_a_work", int'(a_workload), 0);
    chk("rst_a_ready", int'(a_load_ready), 1);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_b_out", int'(b_ser_out), 1);
    chk("rst_b_valid", int'(b_ser_valid), 0);
    chk("rst_b_ready", int'(b_load_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 64'hA5, 0, 1'b0, 1'b0);              // LSB-first order
    run_frame(0, 64'h5C, 1, 1'b0, 1'b0);              // stall every 4th cycle
    run_frame(0, 64'h3C, 0, 1'b1, 1'b0);              // busy: 8'hFF held high
    run_frame(0, 64'hFF, 0, 1'b0, 1'b1);              // ...accepted after done
    run_frame(1, 64'h800_0000_0001, 0, 1'b0, 1'b0);   // MSB-first, 44 bits
    run_frame(0, 64'h07, 0, 1'b0, 1'b0);              // parity 1 when enabled
    run_frame(0, 64'h03, 0, 1'b0, 1'b0);              // parity 0 when enabled

    for (int i = 0; i < 12; i++) begin
      d    = (i % 4 == 3) ? 1 : 0;
      mode = int'($urandom_range(0, 2));
      w    = {32'($urandom), 32'($urandom)};
      w    = (d == 1) ? (w & ((64'd1 << WB) - 64'd1)) : (w & 64'hFF);
      run_frame(d, w, mode, 1'b0, 1'b0);
    end

    // Reset mid-frame: takes effect without a clock edge.
    sel = 0; c_valid = 1'b1; c_data = 64'hA5; c_shift = 1'b0;
    @(posedge clk); #1;
    c_valid = 1'b0; c_shift = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(a_ser_valid), 1);
    chk("pre_rst_work", int'(a_workload), WA + PAR - 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(a_ser_valid), 0);
    chk("midrst_out", int'(a_ser_out), 0);
    chk("midrst_work", int'(a_workload), 0);
    chk("midrst_ready", int'(a_load_ready), 1);
    c_shift = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 64'hC3, 2, 1'b0, 1'b0);              // recovery after abort

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
